// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access sizes, exception
// codes, address map bounds, controller states and store lane helpers.
package mem_defs;

    typedef enum logic [1:0] {
        SIZE_ILL  = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10,
        SIZE_WORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DM_ACC,
        ST_BR_WAIT,
        ST_EXC
    } state_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    // Data memory starts at address zero, so only the top bound is needed.
    localparam logic [31:0] DM_LAST = 32'h0000_2FFF;
    localparam logic [31:0] BR_BASE = 32'h0000_7F00;
    localparam logic [31:0] BR_LAST = 32'h0000_7F1F;

    function automatic logic [3:0] store_be(input size_e size, input logic [1:0] lo);
        case (size)
            SIZE_WORD: store_be = 4'b1111;
            SIZE_HALF: store_be = lo[1] ? 4'b1100 : 4'b0011;
            SIZE_BYTE: store_be = 4'b0001 << lo;
            default:   store_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input size_e size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: lane_rep = {4{data[7:0]}};
            SIZE_HALF: lane_rep = {2{data[15:0]}};
            default:   lane_rep = data;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_rdata_align.sv
// Load data lane select and zero/sign extension; shared with the writeback stage.
module rdata_align
    import mem_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SIZE_BYTE: data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SIZE_HALF: data = {{16{is_signed & half_sel[15]}}, half_sel};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage data memory / peripheral bridge access controller.
// Optional bridge timeout (bus error, code 7) enabled by defining DMEM_CTRL_TIMEOUT_EN.
module dmem_ctrl
    import mem_defs::*;
#(
    parameter int unsigned BR_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        req_signed,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        busy,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        br_req,
    output logic        br_we,
    output logic [31:0] br_addr,
    output logic [31:0] br_wdata,
    input  logic        br_ack,
    input  logic [31:0] br_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    input  logic        flush
);

    if (BR_TIMEOUT == 0) begin : g_bad_timeout
        $error("BR_TIMEOUT must be at least 1");
    end

    state_e      state;
    size_e       size_q;
    logic [1:0]  addr_lo_q;
    logic        we_q;
    logic        signed_q;
    logic        flushed_q;
    logic [3:0]  be_q;
    logic [31:0] load_data;

    logic misaligned;
    logic in_dm;
    logic in_br;
    logic bad_req;

`ifdef DMEM_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(BR_TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt;
`endif

    rdata_align u_rdata_align (
        .rdata     (dm_rdata),
        .addr_lo   (addr_lo_q),
        .size      (size_q),
        .is_signed (signed_q),
        .data      (load_data)
    );

    always_comb begin
        misaligned = 1'b0;
        case (size_e'(req_size))
            SIZE_WORD: misaligned = (req_addr[1:0] != 2'b00);
            SIZE_HALF: misaligned = req_addr[0];
            SIZE_BYTE: misaligned = 1'b0;
            default:   misaligned = 1'b1;
        endcase
        in_dm   = (req_addr <= DM_LAST);
        in_br   = (req_addr >= BR_BASE) && (req_addr <= BR_LAST);
        bad_req = misaligned || !(in_dm || (in_br && (req_size == SIZE_WORD)));
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    // Byte enables are registered but gated by a same-cycle flush so a
    // cancelled store never reaches the memory.
    assign dm_be     = be_q & {4{~flush}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            size_q    <= SIZE_ILL;
            addr_lo_q <= '0;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            flushed_q <= 1'b0;
            be_q      <= '0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            br_req    <= 1'b0;
            br_we     <= 1'b0;
            br_addr   <= '0;
            br_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            exc_valid <= 1'b0;
            exc_code  <= '0;
`ifdef DMEM_CTRL_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            exc_valid <= 1'b0;
            exc_code  <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        size_q    <= size_e'(req_size);
                        addr_lo_q <= req_addr[1:0];
                        we_q      <= req_we;
                        signed_q  <= req_signed;
                        flushed_q <= 1'b0;
                        if (bad_req) begin
                            state     <= ST_EXC;
                            exc_valid <= 1'b1;
                            exc_code  <= req_we ? EXC_ADES : EXC_ADEL;
                        end else if (in_dm) begin
                            state    <= ST_DM_ACC;
                            dm_addr  <= {req_addr[31:2], 2'b00};
                            dm_wdata <= lane_rep(size_e'(req_size), req_wdata);
                            be_q     <= req_we ? store_be(size_e'(req_size), req_addr[1:0]) : 4'b0000;
                        end else begin
                            state    <= ST_BR_WAIT;
                            br_req   <= 1'b1;
                            br_we    <= req_we;
                            br_addr  <= req_addr;
                            br_wdata <= req_wdata;
`ifdef DMEM_CTRL_TIMEOUT_EN
                            to_cnt   <= '0;
`endif
                        end
                    end
                end
                ST_DM_ACC: begin
                    state    <= ST_IDLE;
                    be_q     <= '0;
                    dm_addr  <= '0;
                    dm_wdata <= '0;
                    if (!flush) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= we_q ? 32'h0 : load_data;
                    end
                end
                ST_BR_WAIT: begin
                    if (flush) flushed_q <= 1'b1;
                    if (br_ack) begin
                        state    <= ST_IDLE;
                        br_req   <= 1'b0;
                        br_we    <= 1'b0;
                        br_addr  <= '0;
                        br_wdata <= '0;
                        if (!(flush || flushed_q)) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= we_q ? 32'h0 : br_rdata;
                        end
                    end
`ifdef DMEM_CTRL_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(BR_TIMEOUT - 1)) begin
                        state     <= ST_EXC;
                        br_req    <= 1'b0;
                        br_we     <= 1'b0;
                        br_addr   <= '0;
                        br_wdata  <= '0;
                        exc_valid <= 1'b1;
                        exc_code  <= EXC_DBE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ST_EXC: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl; the timeout scenario follows
// whichever DMEM_CTRL_TIMEOUT_EN setting the build uses.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, busy;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        br_req, br_we, br_ack;
    logic [31:0] br_addr, br_wdata, br_rdata;
    logic        rsp_valid, exc_valid, flush;
    logic [31:0] rsp_data;
    logic [4:0]  exc_code;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    dmem_ctrl #(.BR_TIMEOUT(15)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_signed(req_signed),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .busy      (busy),
        .dm_addr   (dm_addr),
        .dm_be     (dm_be),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .br_req    (br_req),
        .br_we     (br_we),
        .br_addr   (br_addr),
        .br_wdata  (br_wdata),
        .br_ack    (br_ack),
        .br_rdata  (br_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .exc_valid (exc_valid),
        .exc_code  (exc_code),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic do_dm(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be_exp, input logic [31:0] wd_exp,
                         input logic [31:0] rsp_exp);
        issue(we, size, sgn, addr, wdata);
        check_eq({tag, ".ready"}, 32'(req_ready), 32'd1);
        tick;
        req_valid = 1'b0;
        check_eq({tag, ".busy"}, 32'(busy), 32'd1);
        check_eq({tag, ".be"}, 32'(dm_be), 32'(be_exp));
        check_eq({tag, ".addr"}, dm_addr, {addr[31:2], 2'b00});
        if (we) check_eq({tag, ".wdata"}, dm_wdata, wd_exp);
        check_eq({tag, ".rsp_early"}, 32'(rsp_valid), 32'd0);
        tick;
        check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, ".rsp_data"}, rsp_data, rsp_exp);
        check_eq({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_exc(input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [4:0] code_exp);
        issue(we, size, 1'b0, addr, 32'h1111_2222);
        tick;
        req_valid = 1'b0;
        check_eq({tag, ".exc_valid"}, 32'(exc_valid), 32'd1);
        check_eq({tag, ".exc_code"}, 32'(exc_code), 32'(code_exp));
        check_eq({tag, ".be"}, 32'(dm_be), 32'd0);
        check_eq({tag, ".br_req"}, 32'(br_req), 32'd0);
        tick;
        check_eq({tag, ".exc_pulse"}, 32'(exc_valid), 32'd0);
        check_eq({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int unsigned cnt;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_signed = 1'b0;
        req_size = 2'b11; req_addr = '0; req_wdata = '0;
        dm_rdata = 32'h8001_7F80; br_ack = 1'b0; br_rdata = '0; flush = 1'b0;

        #12;
        check_eq("rst.ready", 32'(req_ready), 32'd1);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.be", 32'(dm_be), 32'd0);
        check_eq("rst.br_req", 32'(br_req), 32'd0);
        check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst.exc_valid", 32'(exc_valid), 32'd0);
        check_eq("rst.exc_code", 32'(exc_code), 32'd0);
        check_eq("rst.dm_wdata", dm_wdata, 32'd0);
        reset = 1'b1;
        tick;

        // stores
        do_dm("sb102", 1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h0000_00A5, 4'b0100, 32'hA5A5_A5A5, 32'h0);
        do_dm("sh102", 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        do_dm("sh100", 1'b1, 2'b01, 1'b0, 32'h0000_0100, 32'h0000_1234, 4'b0011, 32'h1234_1234, 32'h0);
        do_dm("sw2ffc", 1'b1, 2'b11, 1'b0, 32'h0000_2FFC, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0);
        do_dm("sb001", 1'b1, 2'b10, 1'b0, 32'h0000_0001, 32'h0000_0037, 4'b0010, 32'h3737_3737, 32'h0);
        // loads from dm_rdata = 0x8001_7F80
        do_dm("lb103", 1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FF80);
        do_dm("lbu103", 1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0, 4'b0000, 32'h0, 32'h0000_0080);
        do_dm("lb101", 1'b0, 2'b10, 1'b1, 32'h0000_0101, 32'h0, 4'b0000, 32'h0, 32'h0000_007F);
        do_dm("lhu102", 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 4'b0000, 32'h0, 32'h0000_8001);
        do_dm("lh102", 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 4'b0000, 32'h0, 32'hFFFF_8001);
        do_dm("lh100", 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 4'b0000, 32'h0, 32'h0000_7F80);
        do_dm("lw100", 1'b0, 2'b11, 1'b1, 32'h0000_0100, 32'h0, 4'b0000, 32'h0, 32'h8001_7F80);
        tick;
        check_eq("rsp_pulse", 32'(rsp_valid), 32'd0);

        // address errors
        do_exc("lw006", 1'b0, 2'b11, 32'h0000_0006, 5'd4);
        do_exc("sh3000", 1'b1, 2'b01, 32'h0000_3000, 5'd5);
        do_exc("sh101", 1'b1, 2'b01, 32'h0000_0101, 5'd5);
        do_exc("size00", 1'b0, 2'b00, 32'h0000_0000, 5'd4);
        do_exc("lhbr", 1'b0, 2'b01, 32'h0000_7F04, 5'd4);
        do_exc("sw7f20", 1'b1, 2'b11, 32'h0000_7F20, 5'd5);

        // bridge load, ack on the third wait cycle
        issue(1'b0, 2'b11, 1'b0, 32'h0000_7F04, 32'h0);
        tick;
        req_valid = 1'b0;
        check_eq("brl.req", 32'(br_req), 32'd1);
        check_eq("brl.addr", br_addr, 32'h0000_7F04);
        check_eq("brl.we", 32'(br_we), 32'd0);
        check_eq("brl.ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick;
            check_eq("brl.hold", 32'(br_req), 32'd1);
            check_eq("brl.no_rsp", 32'(rsp_valid), 32'd0);
        end
        br_ack = 1'b1; br_rdata = 32'h1234_5678;
        tick;
        br_ack = 1'b0;
        check_eq("brl.rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("brl.rsp_data", rsp_data, 32'h1234_5678);
        check_eq("brl.req_drop", 32'(br_req), 32'd0);
        check_eq("brl.idle", 32'(busy), 32'd0);

        // bridge store, immediate ack
        issue(1'b1, 2'b11, 1'b0, 32'h0000_7F10, 32'hDEAD_BEEF);
        tick;
        req_valid = 1'b0;
        check_eq("brs.we", 32'(br_we), 32'd1);
        check_eq("brs.wdata", br_wdata, 32'hDEAD_BEEF);
        br_ack = 1'b1;
        tick;
        br_ack = 1'b0;
        check_eq("brs.rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("brs.rsp_data", rsp_data, 32'h0);

        // br_ack while idle is ignored
        br_ack = 1'b1;
        tick;
        br_ack = 1'b0;
        check_eq("ack_idle.rsp", 32'(rsp_valid), 32'd0);
        check_eq("ack_idle.busy", 32'(busy), 32'd0);

        // flush while idle blocks acceptance
        issue(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h5555_AAAA);
        flush = 1'b1;
        tick;
        req_valid = 1'b0; flush = 1'b0;
        check_eq("flush_idle.busy", 32'(busy), 32'd0);
        check_eq("flush_idle.be", 32'(dm_be), 32'd0);

        // flush in DM_ACC suppresses write and response
        issue(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h5555_AAAA);
        tick;
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        check_eq("flush_dm.be", 32'(dm_be), 32'd0);
        tick;
        flush = 1'b0;
        check_eq("flush_dm.rsp", 32'(rsp_valid), 32'd0);
        check_eq("flush_dm.idle", 32'(busy), 32'd0);

        // flush in BR_WAIT: wait for ack, no response
        issue(1'b0, 2'b11, 1'b0, 32'h0000_7F00, 32'h0);
        tick;
        req_valid = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check_eq("flush_br.hold", 32'(br_req), 32'd1);
        br_ack = 1'b1; br_rdata = 32'hABCD_0123;
        tick;
        br_ack = 1'b0;
        check_eq("flush_br.rsp", 32'(rsp_valid), 32'd0);
        check_eq("flush_br.req", 32'(br_req), 32'd0);
        check_eq("flush_br.idle", 32'(busy), 32'd0);

        // reset in BR_WAIT clears outputs immediately
        issue(1'b0, 2'b11, 1'b0, 32'h0000_7F08, 32'h0);
        tick;
        req_valid = 1'b0;
        check_eq("rst_br.req_before", 32'(br_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_br.req", 32'(br_req), 32'd0);
        check_eq("rst_br.busy", 32'(busy), 32'd0);
        check_eq("rst_br.ready", 32'(req_ready), 32'd1);
        #2 reset = 1'b1;
        br_ack = 1'b1;
        tick;
        br_ack = 1'b0;
        check_eq("rst_br.rsp", 32'(rsp_valid), 32'd0);
        check_eq("rst_br.exc", 32'(exc_valid), 32'd0);
        tick;

        // bridge without ack
        issue(1'b0, 2'b11, 1'b0, 32'h0000_7F00, 32'h0);
        tick;
        req_valid = 1'b0;
`ifdef DMEM_CTRL_TIMEOUT_EN
        cnt = 0;
        while (br_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick;
        end
        check_eq("to.req_cycles", cnt, 32'd15);
        check_eq("to.exc_valid", 32'(exc_valid), 32'd1);
        check_eq("to.exc_code", 32'(exc_code), 32'd7);
        tick;
        check_eq("to.idle", 32'(busy), 32'd0);
        check_eq("to.exc_pulse", 32'(exc_valid), 32'd0);
`else
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (exc_valid === 1'b1) cnt++;
            tick;
        end
        check_eq("noto.exc_seen", cnt, 32'd0);
        check_eq("noto.req", 32'(br_req), 32'd1);
        check_eq("noto.busy", 32'(busy), 32'd1);
        br_ack = 1'b1; br_rdata = 32'h0F0F_0F0F;
        tick;
        br_ack = 1'b0;
        check_eq("noto.rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("noto.rsp_data", rsp_data, 32'h0F0F_0F0F);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter BR_TIMEOUT, default 15; bridge wait-cycle limit before bus error.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid/req_we/req_signed  in  1 each  M-stage access request, store flag, sign-extend flag.
REQ-005 req_size  in  2  11=word, 01=half, 10=byte; 00 is illegal and raises AdEL/AdES.
REQ-006 req_addr/req_wdata  in  32 each  byte address, store data (right-justified).
REQ-007 req_ready  out  1  high only in IDLE; a request is accepted when req_valid&req_ready.
REQ-008 busy  out  1  high in every state except IDLE; pipeline stall source.
REQ-009 dm_addr  out  32 (word-aligned); dm_be  out  4  byte write enables; dm_wdata  out  32  lane-replicated; dm_rdata  in  32  asynchronous-read data.
REQ-010 br_req/br_we  out  1 each; br_addr/br_wdata  out  32 each; br_ack  in  1; br_rdata  in  32  peripheral bridge.
REQ-011 rsp_valid  out  1  one-cycle load/store completion pulse; rsp_data  out  32  aligned, extended load data.
REQ-012 exc_valid  out  1  one-cycle pulse; exc_code  out  5  4=AdEL, 5=AdES, 7=DBE.
REQ-013 flush  in  1  cancels the in-flight request's response.

Function
REQ-014 Address map: DM 0x0000_0000-0x0000_2FFF, bridge 0x0000_7F00-0x0000_7F1F, all else unmapped.
REQ-015 States IDLE, DM_ACC, BR_WAIT, EXC; request fields register on acceptance.
REQ-016 Accepted misaligned (half: addr[0]=1; word: addr[1:0]!=0), size 00, or unmapped request -> EXC; no memory/bridge signal asserted; exc_valid with code 4 (load) or 5 (store) the next cycle, then IDLE.
REQ-017 Legal DM request -> DM_ACC for exactly one cycle; rsp_valid in the following cycle; total latency 2 cycles from acceptance.
REQ-018 dm_be in DM_ACC for stores only: word 1111; half 0011/1100 by addr[1]; byte one-hot by addr[1:0]; 0000 for loads and in all other states.
REQ-019 Legal bridge request -> BR_WAIT; br_req held high until br_ack; rsp_valid the cycle after br_ack; bridge accesses are word-only, smaller sizes raise AdEL/AdES.
REQ-020 Load extraction: half selects [15:0] or [31:16] by addr[1]; byte selects lane by addr[1:0]; zero- or sign-extend per req_signed; word passes unchanged; stores return rsp_data=0.
REQ-021 flush in DM_ACC suppresses the DM write and rsp_valid; flush in BR_WAIT keeps br_req until br_ack, then returns to IDLE without rsp_valid.
REQ-022 flush in IDLE on the same cycle as req_valid blocks acceptance.
REQ-023 br_ack outside BR_WAIT is ignored.

Reset
REQ-024 reset low -> state IDLE; every output 0 except req_ready=1; counters cleared, effective immediately; release is synchronous to clk.
REQ-025 Reset mid-BR_WAIT drops br_req immediately; no rsp_valid or exc_valid is generated for the aborted access.

Configuration
REQ-026 Macro DMEM_CTRL_TIMEOUT_EN defined: a cycle counter in BR_WAIT; at BR_TIMEOUT cycles without br_ack, drop br_req, pulse exc_valid with code 7 next cycle, return to IDLE.
REQ-027 DMEM_CTRL_TIMEOUT_EN undefined: BR_WAIT waits indefinitely; no counter logic; code 7 never produced.

Structure
REQ-028 Shared package mem_defs holds size encodings, exception codes, address-map bounds and the state encoding.
REQ-029 One sub-module, rdata_align: combinational lane select and extension per REQ-020, also used by the writeback stage.

Verification
REQ-030 Store byte 0xA5 at 0x0000_0102 -> dm_be=0100, dm_wdata=0xA5A5A5A5, rsp_valid 2 cycles after acceptance.
REQ-031 dm_rdata=0x8001_7F80; lb signed at 0x...03 -> 0xFFFFFF80; lhu at 0x...02 -> 0x00008001; lh at 0x...00 -> 0x00007F80.
REQ-032 lw at 0x0000_0006 -> exc_valid, exc_code=4, dm_be=0000, br_req=0; sh at 0x0000_3000 -> exc_code=5.
REQ-033 lw at 0x0000_7F04, br_ack after 3 cycles with br_rdata=0x1234_5678 -> rsp_data=0x1234_5678, rsp_valid the cycle after ack.
REQ-034 With DMEM_CTRL_TIMEOUT_EN defined, br_ack never asserted -> br_req drops after 15 cycles, exc_code=7; busy low the cycle after.
REQ-035 flush in BR_WAIT, then ack -> no rsp_valid; reset asserted mid-BR_WAIT -> all outputs idle at once.
